// File: rtl/param_register_file.sv
// Multi-port processor register file with write-to-read bypass, optional
// hardwired zero register and a per-register pending scoreboard.
module param_register_file #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_pending,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [NUM_REGS-1:0]        pending,
    output logic                       conflict
);

    logic [DATA_W-1:0]   regFile [NUM_REGS];
    logic [NUM_REGS-1:0] pendingQ;
    logic [NUM_REGS-1:0] pendingNext;
    logic                conflictQ;
    logic                conflictNext;

    logic [ADDR_W-1:0]   rdAddrA  [NUM_RD];
    logic [ADDR_W-1:0]   wrAddrA  [NUM_WR];
    logic [DATA_W-1:0]   wrDataA  [NUM_WR];

    function automatic logic isZeroAddr(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Unpack flat port buses into per-port views
    always_comb begin
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rdAddrA[p] = rd_addr[p*ADDR_W +: ADDR_W];
        end
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            wrAddrA[w] = wr_addr[w*ADDR_W +: ADDR_W];
            wrDataA[w] = wr_data[w*DATA_W +: DATA_W];
        end
    end

    // Later ports are applied last so the highest-numbered port wins a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regFile[r] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && !isZeroAddr(wrAddrA[w])) begin
                    regFile[wrAddrA[w]] <= wrDataA[w];
                end
            end
        end
    end

    always_comb begin
        conflictNext = 1'b0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            for (int unsigned j = i + 1; j < NUM_WR; j++) begin
                if (wr_en[i] && wr_en[j] && (wrAddrA[i] == wrAddrA[j]) &&
                    !isZeroAddr(wrAddrA[i])) begin
                    conflictNext = 1'b1;
                end
            end
        end
    end

    // Reserve is applied after write clears so back-to-back producers stay pending
    always_comb begin
        pendingNext = pendingQ;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                pendingNext[wrAddrA[w]] = 1'b0;
            end
        end
        if (rsv_en) begin
            pendingNext[rsv_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            pendingNext[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendingQ  <= '0;
            conflictQ <= 1'b0;
        end else begin
            pendingQ  <= pendingNext;
            conflictQ <= conflictNext;
        end
    end

    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_data[p*DATA_W +: DATA_W] = regFile[rdAddrA[p]];
            rd_pending[p]               = pendingQ[rdAddrA[p]];
            if (BYPASS) begin
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && (wrAddrA[w] == rdAddrA[p])) begin
                        rd_data[p*DATA_W +: DATA_W] = wrDataA[w];
                        rd_pending[p] = rsv_en && (rsv_addr == rdAddrA[p]);
                    end
                end
            end
            if (isZeroAddr(rdAddrA[p])) begin
                rd_data[p*DATA_W +: DATA_W] = '0;
                rd_pending[p]               = 1'b0;
            end
        end
    end

    assign pending  = pendingQ;
    assign conflict = conflictQ;

endmodule

// File: tb/tb_param_register_file.sv
// Directed checks of param_register_file (bypass and non-bypass builds) plus a
// randomised reference-model sweep on a wide, 3-read/1-write configuration.
module tb_param_register_file;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Default configuration inputs, shared by the bypass and non-bypass instances
    logic [7:0]  rdAddr  = '0;
    logic [1:0]  wrEn    = '0;
    logic [7:0]  wrAddr  = '0;
    logic [63:0] wrData  = '0;
    logic        rsvEn   = 1'b0;
    logic [3:0]  rsvAddr = '0;

    logic [63:0] rdData,  rdDataNb;
    logic [1:0]  rdPend,  rdPendNb;
    logic [15:0] pendV,   pendNb;
    logic        confV,   confNb;

    // Sweep configuration
    logic [14:0]  sRdAddr  = '0;
    logic [191:0] sRdData;
    logic [2:0]   sRdPend;
    logic         sWrEn    = 1'b0;
    logic [4:0]   sWrAddr  = '0;
    logic [63:0]  sWrData  = '0;
    logic [4:0]   sRsvAddr = '0;
    logic [31:0]  sPend;
    logic         sConf;

    logic [63:0]  model [32];

    param_register_file dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rdAddr), .rd_data(rdData), .rd_pending(rdPend),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr),
        .pending(pendV), .conflict(confV)
    );

    param_register_file #(.BYPASS(1'b0)) dutNb (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rdAddr), .rd_data(rdDataNb), .rd_pending(rdPendNb),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr),
        .pending(pendNb), .conflict(confNb)
    );

    param_register_file #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(3), .NUM_WR(1)) dutSw (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(sRdAddr), .rd_data(sRdData), .rd_pending(sRdPend),
        .wr_en(sWrEn), .wr_addr(sWrAddr), .wr_data(sWrData),
        .rsv_en(1'b0), .rsv_addr(sRsvAddr),
        .pending(sPend), .conflict(sConf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pending", 64'(pendV), 64'h0);
        chk("rst_conflict", 64'(confV), 64'h0);
        chk("rst_rd", rdData, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Basic write on port0, read back on port1
        wrEn = 2'b01; wrAddr = 8'h03; wrData = 64'h0000_0000_1234_5678;
        tick();
        wrEn = 2'b00; rdAddr = 8'h30;
        #1;
        chk("rd_r3", 64'(rdData[63:32]), 64'h1234_5678);
        chk("rd_r3_nb", 64'(rdDataNb[63:32]), 64'h1234_5678);

        // Writes to r0 never become visible
        wrEn = 2'b01; wrAddr = 8'h00; wrData = 64'h0000_0000_FFFF_FFFF; rdAddr = 8'h00;
        #1;
        chk("r0_bypass", 64'(rdData[31:0]), 64'h0);
        tick();
        wrEn = 2'b00;
        #1;
        chk("r0_stored", 64'(rdData[31:0]), 64'h0);

        // Same-cycle bypass from write port1 to read port0
        wrEn = 2'b10; wrAddr = 8'h70; wrData = 64'hA5A5_A5A5_0000_0000; rdAddr = 8'h07;
        #1;
        chk("bypass_r7", 64'(rdData[31:0]), 64'hA5A5_A5A5);
        chk("nobypass_r7", 64'(rdDataNb[31:0]), 64'h0);
        tick();
        wrEn = 2'b00;
        #1;
        chk("nobypass_r7_after", 64'(rdDataNb[31:0]), 64'hA5A5_A5A5);

        // Write collision on r9: port1 wins, conflict pulses for one cycle
        wrEn = 2'b11; wrAddr = 8'h99; wrData = 64'h0000_2222_0000_1111;
        #1;
        chk("conflict_pre", 64'(confV), 64'h0);
        tick();
        wrEn = 2'b00; rdAddr = 8'h09;
        #1;
        chk("conflict_set", 64'(confV), 64'h1);
        chk("conflict_set_nb", 64'(confNb), 64'h1);
        chk("collide_r9", 64'(rdData[31:0]), 64'h2222);
        tick();
        chk("conflict_clear", 64'(confV), 64'h0);

        // Collision on r0 does not raise conflict
        wrEn = 2'b11; wrAddr = 8'h00; wrData = 64'h0000_2222_0000_1111;
        tick();
        wrEn = 2'b00;
        #1;
        chk("conflict_r0", 64'(confV), 64'h0);

        // Scoreboard: reserve r4, release by a later write
        rsvEn = 1'b1; rsvAddr = 4'd4;
        tick();
        rsvEn = 1'b0; rdAddr = 8'h04;
        #1;
        chk("rsv_pending", 64'(pendV), 64'h0010);
        chk("rsv_rd_pending", 64'(rdPend[0]), 64'h1);
        tick();
        wrEn = 2'b01; wrAddr = 8'h04; wrData = 64'h0000_0000_0BAD_F00D;
        #1;
        chk("wr_rd_pending_bypass", 64'(rdPend[0]), 64'h0);
        chk("wr_rd_pending_nb", 64'(rdPendNb[0]), 64'h1);
        tick();
        wrEn = 2'b00;
        #1;
        chk("wr_clears_pending", 64'(pendV), 64'h0);

        // Reserve and write same register in one cycle: reserve wins, data lands
        rsvEn = 1'b1; rsvAddr = 4'd4;
        wrEn = 2'b01; wrAddr = 8'h04; wrData = 64'h0000_0000_CAFE_F00D;
        #1;
        chk("rsv_wr_rd_pending", 64'(rdPend[0]), 64'h1);
        chk("rsv_wr_bypass", 64'(rdData[31:0]), 64'hCAFE_F00D);
        tick();
        wrEn = 2'b00; rsvEn = 1'b0;
        #1;
        chk("rsv_wr_pending", 64'(pendV), 64'h0010);
        chk("rsv_wr_data", 64'(rdData[31:0]), 64'hCAFE_F00D);

        // Reserve of r0 is ignored
        rsvEn = 1'b1; rsvAddr = 4'd0;
        tick();
        rsvEn = 1'b0;
        #1;
        chk("rsv_r0", 64'(pendV), 64'h0010);

        // Asynchronous reset mid-cycle
        wrEn = 2'b01; wrAddr = 8'h05; wrData = 64'h0000_0000_DEAD_BEEF;
        tick();
        wrEn = 2'b00; rdAddr = 8'h05;
        #1;
        chk("r5_before_rst", 64'(rdData[31:0]), 64'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        chk("r5_async_rst", 64'(rdData[31:0]), 64'h0);
        chk("pending_async_rst", 64'(pendV), 64'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Randomised sweep against a reference model
        for (int r = 0; r < 32; r++) model[r] = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            logic [4:0]  a;
            logic [63:0] exp;
            sWrEn   = 1'($urandom_range(0, 1));
            sWrAddr = 5'($urandom_range(0, 31));
            sWrData = {32'($urandom), 32'($urandom)};
            for (int p = 0; p < 3; p++) sRdAddr[p*5 +: 5] = 5'($urandom_range(0, 31));
            #1;
            for (int p = 0; p < 3; p++) begin
                a   = sRdAddr[p*5 +: 5];
                exp = model[a];
                if (sWrEn && (sWrAddr == a)) exp = sWrData;
                if (a == 5'd0) exp = '0;
                chk("sweep_rd", sRdData[p*64 +: 64], exp);
            end
            tick();
            if (sWrEn && (sWrAddr != 5'd0)) model[sWrAddr] = sWrData;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
Next-generation processor register file with parameterised width, depth, read-port count and write-port count. Adds a clocked write path, asynchronous active-low reset, write-to-read bypass, an optional hardwired zero register, and a per-register pending scoreboard for the multi-cycle core. Sits between decode/issue (reads, reserves) and writeback (writes) in the processor datapath.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 16, number of registers (power of two, >=2)
ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden)
NUM_RD, 2, number of read ports (>=1)
NUM_WR, 2, number of write ports (>=1)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes/reserves
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr  input  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
rd_pending  output  NUM_RD  pending bit of each addressed register
wr_en  input  NUM_WR  write enable per write port
wr_addr  input  NUM_WR*ADDR_W  write addresses
wr_data  input  NUM_WR*DATA_W  write data
rsv_en  input  1  reserve (mark pending) request
rsv_addr  input  ADDR_W  register to reserve
pending  output  NUM_REGS  full scoreboard vector
conflict  output  1  pulse: >=2 enabled write ports hit the same address this cycle

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk): all registers = 0, pending = 0, conflict = 0. rd_data then reads 0 for every address. Deassertion is sampled on next rising edge; no writes occur while rst_n low.
- Writes: on rising clk, for each port w with wr_en[w]=1, reg[wr_addr[w]] <= wr_data[w]. Same-address collision: highest-numbered port wins; conflict registers 1 for exactly that cycle (it is a registered output, valid one cycle after the collision), otherwise 0.
- Reads: combinational, zero latency. rd_data[p] = reg[rd_addr[p]].
- BYPASS=1: if any enabled write port targets rd_addr[p] in the current cycle, rd_data[p] = that write data (highest-numbered matching port) instead of stored value. BYPASS=0: old value until after the edge.
- ZERO_REG=1: address 0 always reads 0 (bypass included), writes to 0 discarded, conflict not raised for address 0, rsv_en to address 0 ignored, pending[0] held 0.
- Scoreboard: on rising clk, rsv_en=1 sets pending[rsv_addr]. Any enabled write to address a clears pending[a]. Same cycle reserve and write to the same address: reserve wins (pending ends 1; models back-to-back producers). rd_pending[p] = pending[rd_addr[p]], combinational; with BYPASS=1 a same-cycle write to rd_addr[p] forces rd_pending[p]=0 unless rsv_en also targets it.
- No hidden state beyond registers, pending vector, conflict flop. Out-of-range addresses impossible (NUM_REGS power of two).
- Write and read of all ports fully concurrent; no stalls, no handshake.

Test Plan:
- Reset: hold rst_n=0 mid-run after writing 0xDEADBEEF to r5 -> rd_data for r5 = 0, pending = 0 immediately (no clk edge needed).
- Basic write/read: write port0 r3=0x12345678, next cycle rd_addr port1=3 -> rd_data port1 = 0x12345678; r0 write of 0xFFFFFFFF -> reads 0 (ZERO_REG=1).
- Bypass: same cycle wr_en[1]=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr port0=7 -> rd_data port0 = 0xA5A5A5A5 before edge; with BYPASS=0 shows prior value 0.
- Collision: port0 and port1 both write r9 (0x1111 / 0x2222) -> r9 = 0x2222, conflict=1 for one cycle then 0; same on r0 -> conflict stays 0.
- Scoreboard: rsv r4 -> pending[4]=1, rd_pending=1; write r4 two cycles later -> pending[4]=0; simultaneous rsv r4 + write r4 -> pending[4]=1, r4 data updated.
- Parameter sweep: NUM_REGS=32, NUM_RD=3, NUM_WR=1, DATA_W=64 -> random writes/reads match a reference model over 1000 cycles.
